// File: rtl/cpu_boot_sequencer_if.sv
// Host program stream into the boot sequencer.
// Valid/ready: a word transfers on a rising edge where host_valid and host_ready are both high;
// host_data must be stable while host_valid is high, and ready never depends combinationally on valid.
interface cpu_boot_sequencer_if;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/cpu_boot_sequencer.sv
// Boot/run controller: streams a program into CPU instruction memory, holds the CPU in reset
// for a settle window, then releases it for a bounded or unbounded run.
module cpu_boot_sequencer #(
  parameter int          DEPTH         = 64,
  parameter int          CNT_W         = 7,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          RUN_CYCLES    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      prog_len,
  cpu_boot_sequencer_if.slave   host,
  output logic                  initialize,
  output logic [31:0]           init_addr,
  output logic [31:0]           init_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      words_loaded,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] len, index;
  logic [31:0]      settle_cnt, run_cnt;
  logic             start_ok, start_bad, hs, last_word;

  assign state_dbg = state;

  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (!abort && start && (state == S_IDLE || state == S_DONE)) begin
      if (prog_len != '0 && prog_len <= CNT_W'(DEPTH)) start_ok  = 1'b1;
      else                                             start_bad = 1'b1;
    end
    // abort drops any handshake landing in the same cycle
    hs        = (state == S_LOAD) && host.host_valid && host.host_ready && !abort;
    last_word = (index == len - CNT_W'(1));

    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_LOAD;
      S_LOAD:         if (hs && last_word) state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == '0) state_nxt = S_RUN;
      S_RUN:          if (RUN_CYCLES != 0 && run_cnt == 32'(RUN_CYCLES - 1)) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      host.host_ready <= 1'b0;
      cpu_rst         <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      initialize      <= 1'b0;
      init_addr       <= '0;
      init_data       <= '0;
      words_loaded    <= '0;
      len             <= '0;
      index           <= '0;
      settle_cnt      <= '0;
      run_cnt         <= '0;
    end else begin
      state           <= state_nxt;
      host.host_ready <= (state_nxt == S_LOAD);
      cpu_rst         <= (state_nxt != S_RUN);
      busy            <= (state_nxt inside {S_LOAD, S_SETTLE, S_RUN});
      done            <= (state_nxt == S_DONE);
      initialize      <= hs;

      if (start_ok) begin
        len          <= prog_len;
        index        <= '0;
        words_loaded <= '0;
        error        <= 1'b0;
      end else if (start_bad) begin
        error <= 1'b1;
      end

      if (hs) begin
        init_addr    <= BASE_ADDR + (32'(index) << 2);
        init_data    <= host.host_data;
        words_loaded <= words_loaded + CNT_W'(1);
        if (!last_word) index <= index + CNT_W'(1);
      end

      // The final write cycle is the first SETTLE cycle, so the reset-only window follows it.
      if (state == S_LOAD && state_nxt == S_SETTLE)
        settle_cnt <= 32'(SETTLE_CYCLES);
      else if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 32'd1;

      if (state != S_RUN && state_nxt == S_RUN)
        run_cnt <= '0;
      else if (state == S_RUN)
        run_cnt <= run_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer: writes are checked by a scoreboard monitor,
// control timing by directed checks in the main sequence.
module tb_cpu_boot_sequencer;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] prog_len = '0;
  logic             initialize, cpu_rst, busy, done, error;
  logic [31:0]      init_addr, init_data;
  logic [CNT_W-1:0] words_loaded;
  logic [2:0]       state_dbg;

  cpu_boot_sequencer_if host_if ();

  cpu_boot_sequencer #(
    .DEPTH(64), .CNT_W(CNT_W), .BASE_ADDR(32'h0), .SETTLE_CYCLES(2), .RUN_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .host(host_if.slave),
    .initialize(initialize), .init_addr(init_addr), .init_data(init_data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && initialize) begin : mon
      logic [63:0] e;
      check("init_while_cpu_running", {31'd0, cpu_rst}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", init_addr, init_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", init_addr, e[63:32]);
        check("write_data", init_data, e[31:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  // Inputs change on the falling edge; host_ready seen here is what the next rising edge uses.
  task automatic load_prog(input int len, input logic [15:0] pat, input int budget);
    int k = 0;
    int c = 0;
    start = 1'b1;
    prog_len = CNT_W'(len);
    @(negedge clk);
    start = 1'b0;
    while (k < len && c < budget) begin
      host_if.host_valid = (c < 16) ? pat[c] : 1'b1;
      host_if.host_data  = prog[k];
      if (host_if.host_valid && host_if.host_ready) begin
        exp_q.push_back({32'(k * 4), prog[k]});
        k++;
      end
      @(negedge clk);
      c++;
    end
    host_if.host_valid = 1'b0;
    check("load_words_accepted", 32'(k), 32'(len));
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int run_len;
    host_if.host_valid = 1'b0;
    host_if.host_data  = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_initialize", {31'd0, initialize}, 32'd0);
    check("rst_host_ready", {31'd0, host_if.host_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // T2 + T4: three words streamed back to back, then settle and a 5-cycle run
    prog[0] = 32'hAA; prog[1] = 32'hBB; prog[2] = 32'hCC; prog[3] = 32'h0;
    load_prog(3, 16'hFFFF, 20);
    check("t2_last_write_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t2_ready_dropped", {31'd0, host_if.host_ready}, 32'd0);
    check("t2_words_loaded", 32'(words_loaded), 32'd3);
    @(negedge clk);
    check("t2_settle1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t2_settle1_init", {31'd0, initialize}, 32'd0);
    @(negedge clk);
    check("t2_settle2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    check("t2_release", {31'd0, cpu_rst}, 32'd0);
    check("t2_busy_run", {31'd0, busy}, 32'd1);
    run_len = 1;
    while (!cpu_rst && run_len < 50) begin
      @(negedge clk);
      if (!cpu_rst) run_len++;
    end
    check("t4_run_length", 32'(run_len), 32'd5);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_busy_cleared", {31'd0, busy}, 32'd0);
    check("t4_state_done", {29'd0, state_dbg}, 32'd4);

    // T3: reload from DONE with gapped valid (1,0,0,1)
    prog[0] = 32'h11; prog[1] = 32'h22;
    load_prog(2, 16'hFFF9, 20);
    check("t3_words_loaded", 32'(words_loaded), 32'd2);
    wait_done(40);

    // T5: invalid lengths, plus the DEPTH boundary
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_idle", {29'd0, state_dbg}, 32'd0);
    check("t5_abort_done_clr", {31'd0, done}, 32'd0);
    start = 1'b1; prog_len = 7'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_len0_error", {31'd0, error}, 32'd1);
    check("t5_len0_ready", {31'd0, host_if.host_ready}, 32'd0);
    check("t5_len0_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clk);
    check("t5_len0_ready_hold", {31'd0, host_if.host_ready}, 32'd0);
    start = 1'b1; prog_len = 7'd64;
    @(negedge clk);
    start = 1'b0;
    check("t5_len64_error_clr", {31'd0, error}, 32'd0);
    check("t5_len64_ready", {31'd0, host_if.host_ready}, 32'd1);
    check("t5_len64_words_clr", 32'(words_loaded), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1; prog_len = 7'd65;
    @(negedge clk);
    start = 1'b0;
    check("t5_len65_error", {31'd0, error}, 32'd1);
    check("t5_len65_ready", {31'd0, host_if.host_ready}, 32'd0);
    check("t5_len65_state", {29'd0, state_dbg}, 32'd0);

    // T6: abort coincides with the second handshake
    start = 1'b1; prog_len = 7'd3;
    @(negedge clk);
    start = 1'b0;
    check("t6_ready", {31'd0, host_if.host_ready}, 32'd1);
    host_if.host_valid = 1'b1; host_if.host_data = 32'hA1;
    exp_q.push_back({32'h0, 32'hA1});
    @(negedge clk);
    host_if.host_data = 32'hA2;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    host_if.host_valid = 1'b0;
    check("t6_state_idle", {29'd0, state_dbg}, 32'd0);
    check("t6_ready_low", {31'd0, host_if.host_ready}, 32'd0);
    check("t6_no_write", {31'd0, initialize}, 32'd0);
    check("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t6_words_loaded", 32'(words_loaded), 32'd1);
    @(negedge clk);
    check("t6_still_no_write", {31'd0, initialize}, 32'd0);

    // T1: asynchronous reset in the middle of LOAD
    prog[0] = 32'hD1;
    start = 1'b1; prog_len = 7'd4;
    @(negedge clk);
    start = 1'b0;
    host_if.host_valid = 1'b1; host_if.host_data = 32'hD1;
    exp_q.push_back({32'h0, 32'hD1});
    @(negedge clk);
    host_if.host_data = 32'hD2;
    #2 rst = 1'b0;
    #1;
    check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t1_initialize", {31'd0, initialize}, 32'd0);
    check("t1_host_ready", {31'd0, host_if.host_ready}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_words_loaded", 32'(words_loaded), 32'd0);
    check("t1_init_addr", init_addr, 32'd0);
    check("t1_init_data", init_data, 32'd0);
    check("t1_state", {29'd0, state_dbg}, 32'd0);
    host_if.host_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t1_after_release_state", {29'd0, state_dbg}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
